exc_commit: RTL
===============

# exc_commit

Exception/interrupt commit unit at the writeback end of the pipeline. It is the producer side of the CSR exception interface. Each retiring instruction brings its pending exception flags, ERTN marker and refetch marker. The unit combines these with the CSR interrupt state (`is`, `lie`, `ie`) and picks one event by fixed priority. It then issues a single-cycle commit pulse (`is_exc` / `is_ertn` / `is_fetch_again` with `excode`, `esubcode`, `badvaddr`, `csr_pc`), flushes the pipeline, and holds writeback until the CSR answers with `exlike`.

## Interface

Parameters:
- TIMEOUT, 4: cycles to wait for `exlike` after the commit pulse before raising `err`.

Ports (clock and reset first):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wb_valid  in  1  retiring instruction present
- wb_ready  out  1  unit accepts the instruction this cycle
- wb_pc  in  32  PC of the retiring instruction
- wb_vaddr  in  32  data virtual address, used for memory-class exceptions
- wb_exc_vec  in  16  exception flags, bit order given in the package
- wb_is_ertn  in  1  instruction is ERTN
- wb_is_refetch  in  1  TLB-maintenance instruction, refetch at pc+4
- is  in  12  CSR interrupt status
- lie  in  12  CSR local interrupt enable
- ie  in  1  CSR global interrupt enable
- exlike  in  1  CSR redirect acknowledge
- is_exc  out  1  exception commit pulse
- is_ertn  out  1  ERTN commit pulse
- is_fetch_again  out  1  refetch commit pulse
- excode  out  6  exception code
- esubcode  out  9  exception subcode
- badvaddr  out  32  bad virtual address
- csr_pc  out  32  ERA value
- flush  out  1  kill all younger instructions
- err  out  1  sticky; `exlike` timeout occurred

## Operation

Exception vector bits, index 0 = highest priority:
- 0 ADEF, 1 TLBR_F, 2 PIF, 3 PPI_F (fetch class)
- 4 SYS, 5 BRK, 6 INE, 7 IPE
- 8 ADEM, 9 ALE, 10 TLBR_M, 11 PIL, 12 PIS, 13 PPI_M, 14 PME (memory class)
- 15 reserved, ignored

Interrupt and event selection:
- Interrupt pending: `int_p = ie & |(is & lie)`. A pending interrupt attaches to the accepted instruction and outranks every exception flag, ERTN and refetch.
- Overall priority: INT > exception vector (lowest index wins) > ERTN > refetch.
- "Event" means any one of: interrupt, nonzero exception vector, ERTN, refetch.

Code mapping for the `excode`/`esubcode` outputs:
- INT: 0x00.
- PIL/PIS/PIF: 0x01/0x02/0x03.
- PME: 0x04.
- PPI_F/PPI_M: 0x07.
- ADEF: 0x08, esubcode 0.
- ADEM: 0x08, esubcode 1.
- ALE: 0x09.
- SYS, BRK, INE, IPE: 0x0B, 0x0C, 0x0D, 0x0E.
- TLBR_F/TLBR_M: 0x3F.
- All codes other than ADEM use esubcode 0.

Bad address source:
- Fetch-class exceptions: `badvaddr = wb_pc`.
- Memory-class exceptions: `badvaddr = wb_vaddr`.
- All other events: `badvaddr` keeps its previous value.

Output holding:
- `csr_pc` = `wb_pc` of the accepted event instruction; held until the next event.
- On ERTN and refetch, `excode` keeps the code of the last committed exception, because the CSR compares `excode` against TLBR during ERTN.

FSM states:
- IDLE: `wb_ready = 1`.
  - Accepted with no event: stay in IDLE, no outputs change.
  - Accepted with an event: latch selection, go to COMMIT.
- COMMIT: exactly one of `is_exc` / `is_ertn` / `is_fetch_again` is high for one cycle. `wb_ready = 0`. Go to WAIT and clear the counter.
- WAIT: `wb_ready = 0`, counter increments each cycle.
  - `exlike = 1`: go to IDLE.
  - Counter reaches TIMEOUT: set `err`, go to IDLE.
- `flush = (state != IDLE) | (accept & event)`.

## Timing

- Reset values:
  - State IDLE.
  - `is_exc`, `is_ertn`, `is_fetch_again`, `flush`, `err` = 0.
  - `excode`, `esubcode`, `badvaddr`, `csr_pc` = 0.
  - `wb_ready = 1`.
- Cycle sequence for an event accepted in cycle 0:
  - Cycle 0: `flush = 1`.
  - Cycle 1: commit pulse; all payload outputs valid and stable.
  - Cycle 2: `exlike` expected from the CSR.
  - Cycle 3: IDLE, `wb_ready = 1`.
- Minimum event-to-event spacing is 3 cycles.
- `wb_valid` while `wb_ready = 0`: the instruction is not consumed; the producer holds it.
- `exlike` seen in IDLE or COMMIT is ignored.
- Reset mid-operation: returns to IDLE within the same cycle edge; no pulse is emitted afterward; `err` is cleared.
- `is`/`lie`/`ie` are sampled only in the accept cycle. A later change does not alter a latched selection.

## Structure

- Shared package holds:
  - exception bit-index constants
  - excode constants (shared with the CSR file)
  - FSM state enum
- One sub-module, `exc_prio_enc`: combinational encoder from {int_p, vector, ertn, refetch} to {kind, excode, esubcode, badv_sel}.

## Test plan

- ALE alone: vec = bit9, pc = 0x1C000100, vaddr = 0x00000003 -> cycle 1: `is_exc`, excode 0x09, badvaddr 0x00000003, csr_pc 0x1C000100; `exlike` in cycle 2 -> `wb_ready = 1` in cycle 3.
- Priority: vec = bits 0 and 9, pc = 0x1C000200 -> excode 0x08, esubcode 0, badvaddr 0x1C000200. Repeat with vec = bit8 only -> esubcode 1, badvaddr = vaddr.
- Interrupt over ERTN: is = 0x800, lie = 0x800, ie = 1, `wb_is_ertn = 1` -> `is_exc`, excode 0x00, no `is_ertn`. Same stimulus with ie = 0 -> `is_ertn`, excode unchanged from the prior exception.
- TLB refetch: `wb_is_refetch = 1`, pc = 0x1C000300 -> `is_fetch_again`, csr_pc 0x1C000300, flush cycles 0-2.
- Timeout: withhold `exlike` -> `err = 1` after 4 WAIT cycles, FSM returns to IDLE. Reset asserted in COMMIT -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/exc_commit_pkg.sv
// Shared constants for the exception commit unit and the CSR file:
// exception bit indices, excode values, FSM state and encoder result types.
package exc_commit_pkg;

    localparam int unsigned VEC_W   = 16;
    localparam int unsigned EXC_BITS = 15;
    localparam int unsigned CODE_W  = 6;
    localparam int unsigned SUB_W   = 9;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned IRQ_W   = 12;

    localparam logic [3:0] EXC_ADEF   = 4'd0;
    localparam logic [3:0] EXC_TLBR_F = 4'd1;
    localparam logic [3:0] EXC_PIF    = 4'd2;
    localparam logic [3:0] EXC_PPI_F  = 4'd3;
    localparam logic [3:0] EXC_SYS    = 4'd4;
    localparam logic [3:0] EXC_BRK    = 4'd5;
    localparam logic [3:0] EXC_INE    = 4'd6;
    localparam logic [3:0] EXC_IPE    = 4'd7;
    localparam logic [3:0] EXC_ADEM   = 4'd8;
    localparam logic [3:0] EXC_ALE    = 4'd9;
    localparam logic [3:0] EXC_TLBR_M = 4'd10;
    localparam logic [3:0] EXC_PIL    = 4'd11;
    localparam logic [3:0] EXC_PIS    = 4'd12;
    localparam logic [3:0] EXC_PPI_M  = 4'd13;
    localparam logic [3:0] EXC_PME    = 4'd14;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE    = 2'd0,
        KIND_EXC     = 2'd1,
        KIND_ERTN    = 2'd2,
        KIND_REFETCH = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        BADV_KEEP  = 2'd0,
        BADV_PC    = 2'd1,
        BADV_VADDR = 2'd2
    } badv_sel_e;

    // Exception bit index to architectural excode.
    function automatic logic [5:0] exc_code(input logic [3:0] idx);
        case (idx)
            EXC_ADEF, EXC_ADEM:   exc_code = ECODE_ADE;
            EXC_TLBR_F, EXC_TLBR_M: exc_code = ECODE_TLBR;
            EXC_PIF:              exc_code = ECODE_PIF;
            EXC_PPI_F, EXC_PPI_M: exc_code = ECODE_PPI;
            EXC_SYS:              exc_code = ECODE_SYS;
            EXC_BRK:              exc_code = ECODE_BRK;
            EXC_INE:              exc_code = ECODE_INE;
            EXC_IPE:              exc_code = ECODE_IPE;
            EXC_ALE:              exc_code = ECODE_ALE;
            EXC_PIL:              exc_code = ECODE_PIL;
            EXC_PIS:              exc_code = ECODE_PIS;
            EXC_PME:              exc_code = ECODE_PME;
            default:              exc_code = ECODE_INT;
        endcase
    endfunction

endpackage

// File: rtl/exc_commit_if.sv
// Writeback-side and CSR-side signals of the exception commit unit.
interface exc_commit_if;
    import exc_commit_pkg::*;

    logic              wb_valid;
    logic              wb_ready;
    logic [XLEN-1:0]   wb_pc;
    logic [XLEN-1:0]   wb_vaddr;
    logic [VEC_W-1:0]  wb_exc_vec;
    logic              wb_is_ertn;
    logic              wb_is_refetch;
    logic [IRQ_W-1:0]  is;
    logic [IRQ_W-1:0]  lie;
    logic              ie;
    logic              exlike;
    logic              is_exc;
    logic              is_ertn;
    logic              is_fetch_again;
    logic [CODE_W-1:0] excode;
    logic [SUB_W-1:0]  esubcode;
    logic [XLEN-1:0]   badvaddr;
    logic [XLEN-1:0]   csr_pc;
    logic              flush;
    logic              err;

    modport master (
        output wb_valid, wb_pc, wb_vaddr, wb_exc_vec, wb_is_ertn, wb_is_refetch,
        output is, lie, ie, exlike,
        input  wb_ready, is_exc, is_ertn, is_fetch_again, excode, esubcode,
        input  badvaddr, csr_pc, flush, err
    );

    modport slave (
        input  wb_valid, wb_pc, wb_vaddr, wb_exc_vec, wb_is_ertn, wb_is_refetch,
        input  is, lie, ie, exlike,
        output wb_ready, is_exc, is_ertn, is_fetch_again, excode, esubcode,
        output badvaddr, csr_pc, flush, err
    );

endinterface

// File: rtl/exc_commit_prio_enc.sv
// Fixed-priority encoder: interrupt > exception vector (lowest index) > ERTN > refetch.
module exc_prio_enc
    import exc_commit_pkg::*;
(
    input  logic             int_p_i,
    input  logic [VEC_W-1:0] vec_i,
    input  logic             ertn_i,
    input  logic             refetch_i,
    output kind_e            kind_o,
    output logic [5:0]       excode_o,
    output logic [8:0]       esubcode_o,
    output badv_sel_e        badv_sel_o
);

    logic [3:0] idx_c;
    logic       hit_c;

    // Lowest set index wins; bit 15 is reserved and never scanned.
    always_comb begin
        idx_c = '0;
        hit_c = 1'b0;
        for (int i = int'(EXC_BITS) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_c = 4'(i);
                hit_c = 1'b1;
            end
        end
    end

    always_comb begin
        kind_o     = KIND_NONE;
        excode_o   = '0;
        esubcode_o = '0;
        badv_sel_o = BADV_KEEP;
        if (int_p_i) begin
            kind_o   = KIND_EXC;
            excode_o = ECODE_INT;
        end else if (hit_c) begin
            kind_o   = KIND_EXC;
            excode_o = exc_code(idx_c);
            if (idx_c == EXC_ADEM) esubcode_o = 9'd1;
            if (idx_c <= EXC_PPI_F)     badv_sel_o = BADV_PC;
            else if (idx_c >= EXC_ADEM) badv_sel_o = BADV_VADDR;
        end else if (ertn_i) begin
            kind_o = KIND_ERTN;
        end else if (refetch_i) begin
            kind_o = KIND_REFETCH;
        end
    end

endmodule

// File: rtl/exc_commit.sv
// Writeback exception/interrupt commit: selects one event, pulses it to the CSR
// file, flushes the pipeline and stalls writeback until the CSR acknowledges.
module exc_commit
    import exc_commit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    exc_commit_if.slave bus
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_exc_q, is_ertn_q, is_fa_q, err_q;
    logic [CODE_W-1:0] excode_q;
    logic [SUB_W-1:0]  esub_q;
    logic [XLEN-1:0]   badv_q, csr_pc_q;

    logic              int_p_c, accept_c, event_c;
    kind_e             kind_c;
    logic [5:0]        code_c;
    logic [8:0]        sub_c;
    badv_sel_e         bsel_c;

    assign int_p_c  = bus.ie & (|(bus.is & bus.lie));
    assign accept_c = bus.wb_valid & (state_q == ST_IDLE);
    assign event_c  = (kind_c != KIND_NONE);

    exc_prio_enc u_enc (
        .int_p_i    (int_p_c),
        .vec_i      (bus.wb_exc_vec),
        .ertn_i     (bus.wb_is_ertn),
        .refetch_i  (bus.wb_is_refetch),
        .kind_o     (kind_c),
        .excode_o   (code_c),
        .esubcode_o (sub_c),
        .badv_sel_o (bsel_c)
    );

    // Control FSM with latched commit payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_exc_q  <= 1'b0;
            is_ertn_q <= 1'b0;
            is_fa_q   <= 1'b0;
            err_q     <= 1'b0;
            excode_q  <= '0;
            esub_q    <= '0;
            badv_q    <= '0;
            csr_pc_q  <= '0;
        end else begin
            is_exc_q  <= 1'b0;
            is_ertn_q <= 1'b0;
            is_fa_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_c && event_c) begin
                        state_q   <= ST_COMMIT;
                        is_exc_q  <= (kind_c == KIND_EXC);
                        is_ertn_q <= (kind_c == KIND_ERTN);
                        is_fa_q   <= (kind_c == KIND_REFETCH);
                        csr_pc_q  <= bus.wb_pc;
                        // ERTN/refetch keep the last exception code for the CSR's TLBR check.
                        if (kind_c == KIND_EXC) begin
                            excode_q <= code_c;
                            esub_q   <= sub_c;
                        end
                        case (bsel_c)
                            BADV_PC:    badv_q <= bus.wb_pc;
                            BADV_VADDR: badv_q <= bus.wb_vaddr;
                            default:    ;
                        endcase
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= '0;
                end
                ST_WAIT: begin
                    if (bus.exlike) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.wb_ready       = (state_q == ST_IDLE);
    assign bus.flush          = (state_q != ST_IDLE) | (accept_c & event_c);
    assign bus.is_exc         = is_exc_q;
    assign bus.is_ertn        = is_ertn_q;
    assign bus.is_fetch_again = is_fa_q;
    assign bus.excode         = excode_q;
    assign bus.esubcode       = esub_q;
    assign bus.badvaddr       = badv_q;
    assign bus.csr_pc         = csr_pc_q;
    assign bus.err            = err_q;

endmodule
